// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared types and constants for the fetch-to-decode instruction queue
package fetch_queue_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc4;
  } fetch_entry_t;

  typedef struct packed {
    logic         flush;
    logic         push_valid;
    fetch_entry_t push;
    logic         pop_ready;
  } fetch_queue_in_t;

  // Occupancy count depends on DEPTH, so it stays a separate port.
  typedef struct packed {
    logic         full;
    logic         pop_valid;
    fetch_entry_t pop;
  } fetch_queue_out_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order circular queue between fetch and decode with flush
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int PC_SIZE   = PC_W,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  flush_in,
  input  logic                  push_valid_in,
  input  logic [DATA_WIDTH-1:0] push_inst_in,
  input  logic [PC_SIZE-1:0]    push_pc_in,
  input  logic [PC_SIZE-1:0]    push_pc4_in,
  output logic                  full_out,
  input  logic                  pop_ready_in,
  output logic                  pop_valid_out,
  output logic [DATA_WIDTH-1:0] pop_inst_out,
  output logic [PC_SIZE-1:0]    pop_pc_out,
  output logic [PC_SIZE-1:0]    pop_pc4_out,
  output logic [CNT_W-1:0]      count_out
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_queue_in_t  in_s;
  fetch_queue_out_t out_s;

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fetch_entry_t     mem_q [DEPTH];

  logic full, valid, push_fire, pop_fire;

  assign in_s.flush      = flush_in;
  assign in_s.push_valid = push_valid_in;
  assign in_s.push.inst  = push_inst_in;
  assign in_s.push.pc    = push_pc_in;
  assign in_s.push.pc4   = push_pc4_in;
  assign in_s.pop_ready  = pop_ready_in;

  // Flags come from registered count only, so fetch stall has no combinational path from inputs.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign valid     = (count_q != '0);
  assign push_fire = in_s.push_valid && !full;
  assign pop_fire  = valid && in_s.pop_ready;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (in_s.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_fire) wptr_d = wptr_q + PTR_W'(1);
      if (pop_fire)  rptr_d = rptr_q + PTR_W'(1);
      case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: stale entries are masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (push_fire && !in_s.flush) mem_q[wptr_q] <= in_s.push;
  end

  always_comb begin
    out_s.full      = full;
    out_s.pop_valid = valid;
    out_s.pop.inst  = NOP_INST;
    out_s.pop.pc    = '0;
    out_s.pop.pc4   = '0;
    if (valid) out_s.pop = mem_q[rptr_q];
  end

  assign full_out      = out_s.full;
  assign pop_valid_out = out_s.pop_valid;
  assign pop_inst_out  = out_s.pop.inst;
  assign pop_pc_out    = out_s.pop.pc;
  assign pop_pc4_out   = out_s.pop.pc4;
  assign count_out     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized and directed bench for fetch_queue against a queue model
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          flush_in = 1'b0;
  logic          push_valid_in = 1'b0;
  logic [DW-1:0] push_inst_in = '0;
  logic [31:0]   push_pc_in = '0;
  logic [31:0]   push_pc4_in = '0;
  logic          pop_ready_in = 1'b0;
  logic          full_out, pop_valid_out;
  logic [DW-1:0] pop_inst_out;
  logic [31:0]   pop_pc_out, pop_pc4_out;
  logic [CW-1:0] count_out;

  fetch_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .arst_n(arst_n), .flush_in(flush_in),
    .push_valid_in(push_valid_in), .push_inst_in(push_inst_in),
    .push_pc_in(push_pc_in), .push_pc4_in(push_pc4_in),
    .full_out(full_out), .pop_ready_in(pop_ready_in),
    .pop_valid_out(pop_valid_out), .pop_inst_out(pop_inst_out),
    .pop_pc_out(pop_pc_out), .pop_pc4_out(pop_pc4_out), .count_out(count_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  fetch_entry_t model[$];
  logic [31:0]  popped[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string ctx);
    int n = model.size();
    check_eq({ctx, ".count"}, 32'(count_out), 32'(n));
    check_eq({ctx, ".valid"}, 32'(pop_valid_out), 32'(n != 0));
    check_eq({ctx, ".full"}, 32'(full_out), 32'(n == DEPTH));
    check_eq({ctx, ".inst"}, pop_inst_out, (n != 0) ? model[0].inst : 32'h00000013);
    check_eq({ctx, ".pc"}, pop_pc_out, (n != 0) ? model[0].pc : 32'h0);
    check_eq({ctx, ".pc4"}, pop_pc4_out, (n != 0) ? model[0].pc4 : 32'h0);
  endtask

  // One clock: drive inputs, advance the model by the queue rules, compare just after the edge.
  task automatic cycle(input bit flush, input bit push, input bit pop, input logic [31:0] pc, input string ctx);
    fetch_entry_t e;
    bit push_ok, pop_ok;
    e.inst = $urandom;
    e.pc   = pc;
    e.pc4  = pc + 32'd4;
    flush_in      = flush;
    push_valid_in = push;
    pop_ready_in  = pop;
    push_inst_in  = e.inst;
    push_pc_in    = e.pc;
    push_pc4_in   = e.pc4;
    push_ok = push && (model.size() < DEPTH);
    pop_ok  = pop && (model.size() > 0);
    @(posedge clk);
    if (flush) model.delete();
    else begin
      if (pop_ok) begin
        popped.push_back(model[0].pc);
        void'(model.pop_front());
      end
      if (push_ok) model.push_back(e);
    end
    #1;
    flush_in = 1'b0; push_valid_in = 1'b0; pop_ready_in = 1'b0;
    check_outputs(ctx);
  endtask

  initial begin
    #1;
    check_outputs("in_reset");
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    check_outputs("after_reset");

    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 32'(i * 4), "fill");
    check_eq("fill.count_stays4", 32'(count_out), 32'd4);
    popped.delete();
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 32'h0, "drain");
    for (int i = 0; i < 4; i++) check_eq("drain.order", popped[i], 32'(i * 4));
    cycle(0, 0, 1, 32'h0, "underflow");

    cycle(0, 1, 0, 32'h40, "c2a");
    cycle(0, 1, 0, 32'h44, "c2b");
    cycle(0, 1, 1, 32'h48, "c2_pushpop");
    check_eq("c2.count", 32'(count_out), 32'd2);
    check_eq("c2.head", pop_pc_out, 32'h44);

    cycle(0, 1, 0, 32'h4c, "c3");
    cycle(1, 1, 1, 32'h777, "flush");
    check_eq("flush.count", 32'(count_out), 32'd0);
    check_eq("flush.valid", 32'(pop_valid_out), 32'd0);
    cycle(0, 0, 1, 32'h0, "post_flush_idle");

    popped.delete();
    cycle(0, 1, 0, 32'h100, "prefill");
    for (int i = 1; i <= 10; i++) begin
      cycle(0, 1, 1, 32'h100 + 32'(i * 4), "wrap");
      check_eq("wrap.count1", 32'(count_out), 32'd1);
    end
    for (int i = 0; i < 10; i++) check_eq("wrap.order", popped[i], 32'h100 + 32'(i * 4));

    cycle(1, 0, 0, 32'h0, "flush2");
    cycle(0, 1, 1, 32'h200, "empty_pushpop");
    check_eq("empty_pushpop.count", 32'(count_out), 32'd1);
    check_eq("empty_pushpop.pc", pop_pc_out, 32'h200);

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 19) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom & 32'hffff_fffc, "rand");
      if (i == 200) begin
        #2 arst_n = 1'b0;
        #1 model.delete();
        check_outputs("mid_reset");
        @(negedge clk);
        arst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
